// File: rtl/cmsdk_mcu_ahb_resp_mux_pkg.sv
// Shared definitions for the AHB data-phase response multiplexer and its
// built-in default slave.
package cmsdk_mcu_ahb_resp_mux_pkg;

    localparam int NUM_SLV   = 6;
    localparam int SLV_FLASH = 0;
    localparam int SLV_SDRAM = 1;
    localparam int SLV_APB   = 2;
    localparam int SLV_CPU2  = 3;
    localparam int SLV_DMA   = 4;
    localparam int SLV_DEF   = 5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    function automatic logic isActiveTrans(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

    // Lowest index wins, so the slave ordering above doubles as the priority order.
    function automatic logic [NUM_SLV-1:0] prioritySelect(input logic [NUM_SLV-1:0] v);
        return v & (~v + {{(NUM_SLV-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic multiHot(input logic [NUM_SLV-1:0] v);
        return (v & (v - {{(NUM_SLV-1){1'b0}}, 1'b1})) != '0;
    endfunction

endpackage

// File: rtl/cmsdk_mcu_ahb_default_slave.sv
// Default slave for unmapped regions: answers NONSEQ/SEQ with a two-cycle
// ERROR response and IDLE/BUSY with a zero-wait OKAY.
module cmsdk_mcu_ahb_default_slave
    import cmsdk_mcu_ahb_resp_mux_pkg::*;
(
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hsel,
    input  logic [1:0] htrans,
    input  logic       hready,
    output logic       hreadyout,
    output logic       hresp
);

    ds_state_e state_q, state_d;
    logic      newErr;

    assign newErr = hready & hsel & isActiveTrans(htrans);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (newErr) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                hresp   = 1'b1;
                state_d = newErr ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cmsdk_mcu_ahb_resp_mux.sv
// AHB-Lite return-path multiplexer: registers the decoder's one-hot select at
// each accepted address phase and routes that slave's response to the master.
module cmsdk_mcu_ahb_resp_mux
    import cmsdk_mcu_ahb_resp_mux_pkg::*;
#(
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   ERR_RDATA = '0
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic [1:0]    htrans,
    input  logic          hready,
    input  logic          flash_hsel,
    input  logic          sdram_hsel,
    input  logic          apbbus_hsel,
    input  logic          cpu2_hsel,
    input  logic          dma_hsel,
    input  logic          defslv_hsel,
    input  logic          flash_hreadyout,
    input  logic          sdram_hreadyout,
    input  logic          apbbus_hreadyout,
    input  logic          cpu2_hreadyout,
    input  logic          dma_hreadyout,
    input  logic          flash_hresp,
    input  logic          sdram_hresp,
    input  logic          apbbus_hresp,
    input  logic          cpu2_hresp,
    input  logic          dma_hresp,
    input  logic [DW-1:0] flash_hrdata,
    input  logic [DW-1:0] sdram_hrdata,
    input  logic [DW-1:0] apbbus_hrdata,
    input  logic [DW-1:0] cpu2_hrdata,
    input  logic [DW-1:0] dma_hrdata,
    output logic          hready_out,
    output logic          hresp_out,
    output logic [DW-1:0] hrdata_out,
    output logic          sel_conflict
);

    logic [NUM_SLV-1:0] hselVec;
    logic [NUM_SLV-1:0] hselPri;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic               conflict_q, conflict_d;
    logic               dsReadyOut;
    logic               dsResp;

    always_comb begin
        hselVec            = '0;
        hselVec[SLV_FLASH] = flash_hsel;
        hselVec[SLV_SDRAM] = sdram_hsel;
        hselVec[SLV_APB]   = apbbus_hsel;
        hselVec[SLV_CPU2]  = cpu2_hsel;
        hselVec[SLV_DMA]   = dma_hsel;
        hselVec[SLV_DEF]   = defslv_hsel;
    end

    assign hselPri = prioritySelect(hselVec);

    always_comb begin
        sel_d      = sel_q;
        conflict_d = conflict_q;
        if (hready) begin
            sel_d = hselPri;
            if (multiHot(hselVec)) begin
                conflict_d = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            sel_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            conflict_q <= conflict_d;
        end
    end

    assign sel_conflict = conflict_q;

    // The FSM sees the priority-filtered select so a masked defslv hit never starts an error.
    cmsdk_mcu_ahb_default_slave u_default_slave (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hselPri[SLV_DEF]),
        .htrans    (htrans),
        .hready    (hready),
        .hreadyout (dsReadyOut),
        .hresp     (dsResp)
    );

    always_comb begin
        hready_out = 1'b1;
        hresp_out  = 1'b0;
        hrdata_out = ERR_RDATA;
        if (sel_q[SLV_FLASH]) begin
            hready_out = flash_hreadyout;
            hresp_out  = flash_hresp;
            hrdata_out = flash_hrdata;
        end else if (sel_q[SLV_SDRAM]) begin
            hready_out = sdram_hreadyout;
            hresp_out  = sdram_hresp;
            hrdata_out = sdram_hrdata;
        end else if (sel_q[SLV_APB]) begin
            hready_out = apbbus_hreadyout;
            hresp_out  = apbbus_hresp;
            hrdata_out = apbbus_hrdata;
        end else if (sel_q[SLV_CPU2]) begin
            hready_out = cpu2_hreadyout;
            hresp_out  = cpu2_hresp;
            hrdata_out = cpu2_hrdata;
        end else if (sel_q[SLV_DMA]) begin
            hready_out = dma_hreadyout;
            hresp_out  = dma_hresp;
            hrdata_out = dma_hrdata;
        end else if (sel_q[SLV_DEF]) begin
            hready_out = dsReadyOut;
            hresp_out  = dsResp;
        end
    end

endmodule

// File: tb/tb_cmsdk_mcu_ahb_resp_mux.sv
// Scoreboard bench: the stimulus side predicts each cycle's response from a
// transfer-level model and queues it; a negedge monitor pops and compares.
module tb_cmsdk_mcu_ahb_resp_mux;

    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic        conf;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [1:0]  htrans;
    logic        hready;
    logic [5:0]  hselDrv;
    logic [4:0]  slvReady;
    logic [4:0]  slvResp;
    logic [31:0] slvData [5];
    logic        hready_out;
    logic        hresp_out;
    logic [31:0] hrdata_out;
    logic        sel_conflict;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Transfer-level model: who owns the data phase, and which error cycle the default slave is in.
    int   owner    = -1;
    int   errPhase = 0;
    bit   confSeen = 0;

    always #5 hclk = ~hclk;

    cmsdk_mcu_ahb_resp_mux #(.DW(32), .ERR_RDATA(ERR_DATA)) dut (
        .hclk             (hclk),
        .hreset           (hreset),
        .htrans           (htrans),
        .hready           (hready),
        .flash_hsel       (hselDrv[0]),
        .sdram_hsel       (hselDrv[1]),
        .apbbus_hsel      (hselDrv[2]),
        .cpu2_hsel        (hselDrv[3]),
        .dma_hsel         (hselDrv[4]),
        .defslv_hsel      (hselDrv[5]),
        .flash_hreadyout  (slvReady[0]),
        .sdram_hreadyout  (slvReady[1]),
        .apbbus_hreadyout (slvReady[2]),
        .cpu2_hreadyout   (slvReady[3]),
        .dma_hreadyout    (slvReady[4]),
        .flash_hresp      (slvResp[0]),
        .sdram_hresp      (slvResp[1]),
        .apbbus_hresp     (slvResp[2]),
        .cpu2_hresp       (slvResp[3]),
        .dma_hresp        (slvResp[4]),
        .flash_hrdata     (slvData[0]),
        .sdram_hrdata     (slvData[1]),
        .apbbus_hrdata    (slvData[2]),
        .cpu2_hrdata      (slvData[3]),
        .dma_hrdata       (slvData[4]),
        .hready_out       (hready_out),
        .hresp_out        (hresp_out),
        .hrdata_out       (hrdata_out),
        .sel_conflict     (sel_conflict)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, predicts the response, then advances the model at the clock edge.
    task automatic applyStimulus(input logic [5:0] sel, input logic [1:0] trans, input logic rst,
                                 input logic [4:0] rdy, input logic [4:0] rsp);
        exp_t e;
        int   nSel;
        hselDrv  = sel;
        htrans   = trans;
        hreset   = rst;
        slvReady = rdy;
        slvResp  = rsp;
        for (int i = 0; i < 5; i++) slvData[i] = $urandom;
        e.data = ERR_DATA;
        if (owner < 0) begin
            e.rdy = 1'b1; e.resp = 1'b0;
        end else if (owner < 5) begin
            e.rdy = rdy[owner]; e.resp = rsp[owner]; e.data = slvData[owner];
        end else begin
            e.rdy  = (errPhase != 1);
            e.resp = (errPhase != 0);
        end
        e.conf = confSeen;
        hready = e.rdy;
        expQ.push_back(e);
        @(posedge hclk);
        if (rst) begin
            owner = -1; errPhase = 0; confSeen = 0;
        end else if (hready) begin
            nSel  = 0;
            owner = -1;
            for (int i = 0; i < 6; i++) begin
                if (sel[i]) begin
                    nSel++;
                    if (owner < 0) owner = i;
                end
            end
            if (nSel > 1) confSeen = 1;
            errPhase = (owner == 5 && trans >= 2) ? 1 : 0;
        end else if (owner == 5 && errPhase == 1) begin
            errPhase = 2;
        end
        #1;
    endtask

    always @(negedge hclk) begin
        exp_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("hready_out", {31'b0, hready_out}, {31'b0, e.rdy});
            checkOutput("hresp_out", {31'b0, hresp_out}, {31'b0, e.resp});
            checkOutput("hrdata_out", hrdata_out, e.data);
            checkOutput("sel_conflict", {31'b0, sel_conflict}, {31'b0, e.conf});
        end
    end

    initial begin
        logic [5:0] sel;
        logic [4:0] rdy;
        logic [4:0] rsp;
        int         r;
        hreset = 1'b1; htrans = 2'b00; hready = 1'b1; hselDrv = '0;
        slvReady = '1; slvResp = '0;
        for (int i = 0; i < 5; i++) slvData[i] = '0;
        @(posedge hclk);
        #1;
        expQ.delete();

        // Directed walk through the main scenarios, then a long randomized run.
        applyStimulus(6'h00, 2'b00, 1'b1, 5'h1F, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h02, 2'b10, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h01, 2'b10, 1'b0, 5'h1D, 5'h00);
        applyStimulus(6'h01, 2'b10, 1'b0, 5'h1D, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h20, 2'b10, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h20, 2'b10, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h20, 2'b11, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h20, 2'b00, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h20, 2'b01, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h11, 2'b10, 1'b0, 5'h1F, 5'h01);
        applyStimulus(6'h04, 2'b10, 1'b0, 5'h1E, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h20, 2'b10, 1'b0, 5'h1F, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b1, 5'h1F, 5'h00);
        applyStimulus(6'h00, 2'b00, 1'b0, 5'h1F, 5'h00);

        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      sel = 6'h00;
            else if (r < 93) sel = 6'(1 << $urandom_range(0, 5));
            else             sel = 6'($urandom);
            for (int i = 0; i < 5; i++) begin
                rdy[i] = ($urandom_range(0, 3) != 0);
                rsp[i] = ($urandom_range(0, 4) == 0);
            end
            applyStimulus(sel, 2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 3), rdy, rsp);
        end

        @(negedge hclk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
